// File: rtl/viterbi_traceback.sv
// Block traceback for a Viterbi decoder: fills one frame of survivor decisions, then emits
// decoded bits last-step-first. Define TB_BEST_STATE_EN to start traceback from best_state_i.
module viterbi_traceback #(
  parameter int K         = 3,
  parameter int FRAME_LEN = 16,
  parameter int PTR_W     = $clog2(FRAME_LEN),
  localparam int MEM        = K - 1,
  localparam int NUM_STATES = 2 ** MEM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_STATES-1:0] dec_i,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [MEM-1:0]        best_state_i,
  output logic                  data_serial_o,
  output logic                  valid_serial_o,
  output logic                  frame_done_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(FRAME_LEN - 1);

  typedef enum logic {S_FILL, S_TRACE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [MEM-1:0]        r_cur;
  logic                  r_data;
  logic                  r_valid;
  logic                  r_done;
  logic [NUM_STATES-1:0] r_mem [FRAME_LEN];

  logic                  w_fill;
  logic                  w_wr_en;
  logic                  w_last_wr;
  logic                  w_dec_bit;
  logic [MEM-1:0]        w_pred;
  logic [MEM-1:0]        w_start;

`ifdef TB_BEST_STATE_EN
  assign w_start = best_state_i;
`else
  logic w_unused_best;
  assign w_unused_best = ^best_state_i;
  assign w_start       = '0;
`endif

  assign w_wr_en   = w_fill & dec_valid_i;
  assign w_last_wr = w_wr_en && (r_wr_ptr == LAST);
  assign w_dec_bit = r_mem[r_rd_ptr][r_cur];
  // Shifting the decision in at the LSB and truncating also covers MEM == 1.
  assign w_pred    = MEM'({r_cur, w_dec_bit});

  always_comb begin
    w_state_nxt = r_state;
    w_fill      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_fill = 1'b1;
        if (w_last_wr) w_state_nxt = S_TRACE;
      end
      S_TRACE: begin
        if (r_rd_ptr == '0) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cur    <= '0;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (w_wr_en) begin
        if (w_last_wr) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= LAST;
          r_cur    <= w_start;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (r_state == S_TRACE) begin
        r_data   <= r_cur[MEM-1];
        r_valid  <= 1'b1;
        r_cur    <= w_pred;
        r_rd_ptr <= r_rd_ptr - 1'b1;
        r_done   <= (r_rd_ptr == '0);
      end
    end
  end

  // Survivor memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= dec_i;
  end

  assign dec_ready_o    = w_fill;
  assign data_serial_o  = r_data;
  assign valid_serial_o = r_valid;
  assign frame_done_o   = r_done;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Bench for viterbi_traceback (K=3, FRAME_LEN=16): frame-level traceback model plus
// directed known-path frames and randomized decision streams.
module tb_viterbi_traceback;

  localparam int FL = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dec_i = '0;
  logic       dec_valid_i = 1'b0;
  logic [1:0] best_state_i = '0;
  logic       dec_ready_o;
  logic       data_serial_o;
  logic       valid_serial_o;
  logic       frame_done_o;

  viterbi_traceback #(.K(3), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .dec_i(dec_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(dec_ready_o), .best_state_i(best_state_i),
    .data_serial_o(data_serial_o), .valid_serial_o(valid_serial_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]    m_vec [FL];
  int            m_cnt = 0;
  int            m_busy = 0;
  bit            m_q [$];
  bit            e_valid = 0, e_bit = 0, e_done = 0;
  logic [FL-1:0] m_frame;
  logic [1:0]    m_start;
  bit            chk_en = 0;

  // Walk the stored frame backwards from the start state; result[t] is the decoded bit of
  // trellis step t, so the MSB is the first bit out.
  function automatic logic [FL-1:0] traceback_bits(input logic [1:0] start);
    logic [FL-1:0] r;
    logic [1:0]    s;
    s = start;
    for (int t = FL - 1; t >= 0; t--) begin
      r[t] = s[1];
      s = {s[0], m_vec[t][s]};
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_busy = 0; e_valid = 0; e_bit = 0; e_done = 0;
      m_q.delete();
    end else if (m_busy > 0) begin
      e_valid = 1;
      e_bit   = m_q.pop_front();
      e_done  = (m_busy == 1);
      m_busy--;
    end else begin
      e_valid = 0;
      e_done  = 0;
      if (dec_valid_i) begin
        m_vec[m_cnt] = dec_i;
        m_cnt++;
        if (m_cnt == FL) begin
`ifdef TB_BEST_STATE_EN
          m_start = best_state_i;
`else
          m_start = 2'b00;
`endif
          m_frame = traceback_bits(m_start);
          for (int k = 0; k < FL; k++) m_q.push_back(m_frame[FL-1-k]);
          m_busy = FL;
          m_cnt  = 0;
        end
      end
    end
  end

  // ---------------- compare + collector ----------------
  logic [15:0] out_sr = '0;
  int          nbits = 0;
  int          ready_low = 0;
  int          done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ready", dec_ready_o, m_busy == 0);
      check("valid", valid_serial_o, e_valid);
      check("done", frame_done_o, e_done);
      if (e_valid) check("data", data_serial_o, e_bit);
    end
    if (valid_serial_o === 1'b1) begin
      out_sr = {out_sr[14:0], data_serial_o};
      nbits++;
    end
    if (dec_ready_o === 1'b0) ready_low++;
    if (frame_done_o === 1'b1) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  logic [3:0] fr [FL];

  task automatic build_path(input logic [15:0] m);
    logic [1:0] s;
    for (int t = 0; t < FL; t++) begin
      s = {m[t], (t > 0) ? m[t-1] : 1'b0};
      fr[t] = 4'($urandom);
      fr[t][s] = (t >= 2) ? m[t-2] : 1'b0;
    end
  endtask

  task automatic clear_counters();
    nbits = 0; ready_low = 0; done_cnt = 0; out_sr = '0;
  endtask

  task automatic send_vecs(input logic [1:0] best, input bit gapped);
    for (int i = 0; i < FL; i++) begin
      dec_valid_i = 1'b1; dec_i = fr[i]; best_state_i = best;
      @(posedge clk); #1;
      if (gapped && i < FL - 1) begin
        dec_valid_i = 1'b0; dec_i = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    dec_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (frame_done_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done at %0t: frame_done_o not seen, expected within 100 cycles", $time);
    end
  endtask

  task automatic run_frame(input logic [1:0] best, input bit gapped, output logic [15:0] got);
    clear_counters();
    send_vecs(best, gapped);
    wait_done();
    @(negedge clk); #1;
    got = out_sr;
  endtask

  // ---------------- test sequence ----------------
  logic [15:0] msg, msg2, got, got_known;
  logic [7:0]  exp_hi;

  initial begin
`ifdef TB_BEST_STATE_EN
    msg = 16'hA5C3; exp_hi = 8'hA5;
`else
    msg = 16'h25C3; exp_hi = 8'h25;
`endif
    msg2 = 16'h3C96;

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_ready", dec_ready_o, 1);
    check("rst_valid", valid_serial_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_data", data_serial_o, 0);
    rst_n = 1'b1;
    clear_counters();
    repeat (40) @(posedge clk);
    #1;
    check("idle_bits", nbits, 0);

    // all-zero frame
    for (int t = 0; t < FL; t++) fr[t] = 4'b0000;
    run_frame(2'b00, 0, got);
    check("zero_out", got, 16'h0000);
    check("zero_nbits", nbits, FL);
    check("zero_ready_low", ready_low, FL);
    check("zero_done_cnt", done_cnt, 1);

    // known path, back-to-back input
    build_path(msg);
    run_frame(msg[15:14], 0, got_known);
    check("known_byte0", got_known[15:8], exp_hi);
    check("known_byte1", got_known[7:0], 8'hC3);
    check("known_nbits", nbits, FL);

    // same frame, gapped input
    build_path(msg);
    run_frame(msg[15:14], 1, got);
    check("gapped_out", got, got_known);
    check("gapped_ready_low", ready_low, FL);

    // back-to-back frames: second starts the cycle after frame_done_o
    build_path(msg);
    run_frame(msg[15:14], 0, got);
    check("b2b_first", got, msg);
    @(posedge clk); #1;
    build_path(msg2);
    run_frame(msg2[15:14], 0, got);
    check("b2b_second", got, msg2);
    check("b2b_done_cnt", done_cnt, 1);

    // reset in the middle of traceback
    build_path(msg);
    clear_counters();
    send_vecs(msg[15:14], 0);
    for (int i = 0; i < 100 && nbits != 5; i++) begin
      @(negedge clk); #1;
    end
    check("mid_nbits", nbits, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_valid", valid_serial_o, 0);
    check("mid_ready", dec_ready_o, 1);
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt, 0);
    check("mid_nbits_after", nbits, 5);
    build_path(msg2);
    run_frame(msg2[15:14], 0, got);
    check("mid_fresh", got, msg2);

`ifdef TB_BEST_STATE_EN
    // all-ones path from best state 2'b11
    for (int t = 0; t < FL; t++) begin
      fr[t] = 4'($urandom);
      fr[t][3] = 1'b1;
    end
    run_frame(2'b11, 0, got);
    check("ones_out", got, 16'hFFFF);
`endif

    // randomized decision stream, valid held high across frame boundaries most of the time
    for (int i = 0; i < 600; i++) begin
      dec_valid_i  = ($urandom_range(0, 3) != 0);
      dec_i        = 4'($urandom);
      best_state_i = 2'($urandom);
      @(posedge clk); #1;
    end
    dec_valid_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
